// File: rtl/prog_seq_pkg.sv
// Shared types and defaults for the programmable sequence generator.
// Holds the FSM state encoding and the default pattern length.
package prog_seq_pkg;

    localparam int DEF_MAX_LEN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/prog_seq_shifter.sv
// Pattern shift register with down-counting bit counter.
// The pattern is stored MSB-aligned so the current bit is always the top bit.
module prog_seq_shifter #(
    parameter int MAX_LEN = 16,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] data,
    input  logic [LW-1:0]      len,
    output logic               bit_out,
    output logic               last
);

    localparam logic [LW-1:0] ML  = LW'(MAX_LEN);
    localparam logic [LW-1:0] ONE = LW'(1);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] sh_q, sh_d;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      cnt_q, cnt_d;

    // Load aligns the pattern; shifting reloads from the saved copy on wrap.
    always_comb begin
        pat_d = pat_q;
        sh_d  = sh_q;
        len_d = len_q;
        cnt_d = cnt_q;
        if (load) begin
            pat_d = data << (ML - len);
            sh_d  = data << (ML - len);
            len_d = len;
            cnt_d = len - ONE;
        end else if (shift) begin
            if (cnt_q == '0) begin
                sh_d  = pat_q;
                cnt_d = len_q - ONE;
            end else begin
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - ONE;
            end
        end
    end

    // Register the shifter state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pat_q <= '0;
            sh_q  <= '0;
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            pat_q <= pat_d;
            sh_q  <= sh_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_out = sh_q[MAX_LEN-1];
    assign last    = (cnt_q == '0);

endmodule

// File: rtl/prog_sequence_gen.sv
// Programmable serial sequence generator: sends a captured pattern
// MSB-first, reps+1 times back-to-back, with abort and length checking.
module prog_sequence_gen
    import prog_seq_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int REP_W   = 4,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LW-1:0]      len,
    input  logic [REP_W-1:0]   reps,
    input  logic               abort,
    output logic               dout,
    output logic               dout_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             state_q, state_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               err_q, err_d;
    logic               len_ok;
    logic               accept;
    logic               shift;
    logic               bit_out;
    logic               last;

    assign len_ok = (len != '0) && (len <= LW'(MAX_LEN));
    assign accept = (state_q == IDLE) && start && len_ok;
    assign shift  = (state_q == SEND);

    prog_seq_shifter #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_shifter (
        .clk     (clk),
        .resetn  (resetn),
        .load    (accept),
        .shift   (shift),
        .data    (pattern),
        .len     (len),
        .bit_out (bit_out),
        .last    (last)
    );

    // State, repeat counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            rep_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
        end
    end

    // Next state; abort outranks completion of the final bit.
    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !len_ok) begin
                    err_d = 1'b1;
                end else if (accept) begin
                    rep_d   = reps;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last) begin
                    if (rep_q == '0) begin
                        state_d = DONE;
                    end else begin
                        rep_d = rep_q - REP_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; dout is forced low when idle.
    always_comb begin
        busy       = (state_q == SEND);
        dout_valid = (state_q == SEND);
        dout       = (state_q == SEND) & bit_out;
        done       = (state_q == DONE);
        err        = err_q;
    end

endmodule

// File: tb/tb_prog_sequence_gen.sv
// Randomized self-checking bench for prog_sequence_gen.
// Expected bit streams are built from pattern/len/reps as plain queues.
module tb_prog_sequence_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic        abort;
    logic        dout;
    logic        dout_valid;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    logic [4:0] det     = 5'b0;
    logic [4:0] det_pat = 5'b10110;
    int         match_cnt = 0;

    prog_sequence_gen #(
        .MAX_LEN (16),
        .REP_W   (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .reps       (reps),
        .abort      (abort),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Loopback sequence detector on the serial stream.
    always @(posedge clk) begin
        if (dout_valid) begin
            det <= {det[3:0], dout};
            if ({det[3:0], dout} == det_pat)
                match_cnt <= match_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_outs(input string tag);
        check({tag, ".dout"},  dout,       1'b0);
        check({tag, ".valid"}, dout_valid, 1'b0);
        check({tag, ".busy"},  busy,       1'b0);
        check({tag, ".done"},  done,       1'b0);
    endtask

    // One transmission; abort_at<0 means run to completion.
    task automatic run_tx(input logic [15:0] pat, input int ln, input int rp,
                          input int abort_at, input bit noise);
        bit q[$];
        int n;
        bit aborted;
        for (int r = 0; r <= rp; r++)
            for (int i = ln - 1; i >= 0; i--)
                q.push_back(pat[i]);
        n = q.size();
        aborted = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        pattern = pat;
        len     = 5'(ln);
        reps    = 4'(rp);
        abort   = 1'b0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pattern = 16'($urandom);
        len     = 5'($urandom);
        reps    = 4'($urandom);
        for (int k = 0; k < n && !aborted; k++) begin
            @(negedge clk);
            check("tx.valid", dout_valid, 1'b1);
            check("tx.busy",  busy,       1'b1);
            check("tx.dout",  dout,       q[k]);
            check("tx.done",  done,       1'b0);
            check("tx.err",   err,        1'b0);
            start = noise ? 1'($urandom) : 1'b0;
            if (k == abort_at) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end else begin
                abort = noise ? 1'b0 : 1'b0;
            end
        end
        @(negedge clk);
        if (aborted) begin
            idle_outs("abort");
            abort = 1'b0;
            start = 1'b0;
            @(negedge clk);
            idle_outs("abort.after");
        end else begin
            check("end.done",  done,       1'b1);
            check("end.valid", dout_valid, 1'b0);
            check("end.busy",  busy,       1'b0);
            check("end.dout",  dout,       1'b0);
            start = noise ? 1'($urandom) : 1'b0;
            abort = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            idle_outs("post");
            check("post.err", err, 1'b0);
            start = 1'b0;
            abort = 1'b0;
        end
    endtask

    task automatic run_bad(input logic [4:0] ln);
        @(negedge clk);
        start   = 1'b1;
        len     = ln;
        pattern = 16'($urandom);
        reps    = 4'($urandom);
        @(negedge clk);
        start = 1'b0;
        check("bad.err",   err,        1'b1);
        check("bad.busy",  busy,       1'b0);
        check("bad.valid", dout_valid, 1'b0);
        @(negedge clk);
        check("bad.err2",  err,        1'b0);
        idle_outs("bad2");
    endtask

    task automatic run_reset_mid();
        @(negedge clk);
        start   = 1'b1;
        pattern = 16'h3C96;
        len     = 5'd16;
        reps    = 4'd2;
        @(negedge clk);
        start = 1'b0;
        check("rst.b0", dout, 1'b0);
        @(negedge clk);
        check("rst.b1", dout, 1'b0);
        check("rst.busy", busy, 1'b1);
        resetn = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        idle_outs("rst");
        check("rst.err", err, 1'b0);
        resetn = 1'b1;
        start  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            idle_outs("rst.after");
        end
    endtask

    initial begin
        int ln, rp, n, ab;
        resetn  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_outs("reset");
        check("reset.err", err, 1'b0);
        resetn = 1'b1;

        run_tx(16'b10110, 5, 1, -1, 1'b0);
        check("loop.match2", match_cnt == 2, 1'b1);

        run_tx(16'b10110, 5, 0, -1, 1'b0);
        run_tx(16'b10, 2, 2, -1, 1'b0);
        run_bad(5'd0);
        run_bad(5'd17);
        run_bad(5'd31);
        run_tx(16'hA5A5, 16, 0, 3, 1'b0);
        run_tx(16'h0001, 1, 0, -1, 1'b0);
        run_tx(16'h0000, 1, 0, -1, 1'b1);
        run_tx(16'hFFFF, 16, 0, -1, 1'b1);
        run_tx(16'h1234, 4, 1, 7, 1'b0);
        run_reset_mid();

        for (int t = 0; t < 40; t++) begin
            ln = $urandom_range(1, 16);
            rp = $urandom_range(0, 3);
            n  = ln * (rp + 1);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_tx(16'($urandom), ln, rp, ab, 1'b1);
            if ($urandom_range(0, 4) == 0)
                run_bad(5'($urandom_range(17, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
